// File: rtl/cpu_pkg.sv
// Core-wide datapath constants shared by the ID, forwarding, pipeline-register and writeback blocks.
// Pure constants; no logic.
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: one write port, two raw combinational read ports.
// Write latency 1 cycle, reads 0 cycles; no backpressure, every asserted wr_en commits.
// Asynchronous active-low clear of all entries.
module regfile_core #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the WB value, commits it to the register file, bypasses it to both read ports.
// Write latency 1 cycle; reads, bypass and forwarding outputs are combinational.
// No backpressure: every cycle with a valid nonzero destination commits and is counted.
module wb_regfile #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] address_in,
    input  logic [ADDR_W-1:0] write_reg_addr_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  commit_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(cpu_pkg::REG_ZERO);

    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    logic [DATA_W-1:0] raw_rs;
    logic [DATA_W-1:0] raw_rt;

    assign wb_data = MemtoReg_in ? read_data_in : address_in;
    // Writes to r0 are dropped here so they neither store nor count.
    assign wb_en   = regwrite_in && (write_reg_addr_in != ZERO_ADDR);

    regfile_core #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_en),
        .wr_addr   (write_reg_addr_in),
        .wr_data   (wb_data),
        .rd_addr_a (rs_addr),
        .rd_addr_b (rt_addr),
        .rd_data_a (raw_rs),
        .rd_data_b (raw_rt)
    );

    // Reset is checked first so a bypass cannot leak a value while the file is being cleared.
    function automatic logic [DATA_W-1:0] read_sel(input logic              rst_ok,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] val;
        val = raw;
        if (!rst_ok || addr == ZERO_ADDR) begin
            val = '0;
        end else if (wb_en && addr == write_reg_addr_in) begin
            val = wb_data;
        end
        return val;
    endfunction

    assign rs_data   = read_sel(reset, rs_addr, raw_rs);
    assign rt_data   = read_sel(reset, rt_addr, raw_rt);

    assign fwd_valid = wb_en && reset;
    assign fwd_addr  = write_reg_addr_in;
    assign fwd_data  = wb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_count <= '0;
        end else if (wb_en) begin
            commit_count <= commit_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. Selects the writeback value (memory read data vs ALU result), commits it to the 32-entry architectural register file, and serves two combinational read ports to the ID stage with same-cycle write-through bypass. Also exports the current writeback as a forwarding source and counts committed register writes for debug/perf.

Parameters:
DATA_W, 32, register and datapath width
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register address width (clog2 NUM_REGS)
CNT_W, 32, width of commit counter

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous active-low reset
regwrite_in  input  1  WB write enable from MEM/WB register
MemtoReg_in  input  1  1 = write read_data_in, 0 = write address_in
read_data_in  input  DATA_W  memory load data from MEM/WB
address_in  input  DATA_W  ALU result from MEM/WB
write_reg_addr_in  input  ADDR_W  destination register
rs_addr  input  ADDR_W  read port A address (ID stage)
rt_addr  input  ADDR_W  read port B address (ID stage)
rs_data  output  DATA_W  read port A data
rt_data  output  DATA_W  read port B data
fwd_valid  output  1  current WB will write a nonzero register
fwd_addr  output  ADDR_W  current WB destination
fwd_data  output  DATA_W  current WB value
commit_count  output  CNT_W  number of committed register writes

Behaviour:
- wb_data = MemtoReg_in ? read_data_in : address_in (combinational).
- wb_en = regwrite_in && (write_reg_addr_in != 0).
- Write: on rising clk with reset high and wb_en, regs[write_reg_addr_in] <= wb_data. One-cycle write latency.
- Register 0: never written; always reads 0, even when write_reg_addr_in = 0 with regwrite_in = 1 (write discarded, not counted).
- Read ports combinational. Per port, priority: addr == 0 -> 0; else wb_en && addr == write_reg_addr_in -> wb_data (write-through bypass, same cycle); else regs[addr].
- Both ports may address the same register; both get identical data, including bypass.
- fwd_valid = wb_en; fwd_addr = write_reg_addr_in; fwd_data = wb_data. Combinational, no latency.
- commit_count: increments by 1 on each rising clk where wb_en = 1; wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (reset = 0, asynchronous assertion): all regs cleared to 0, commit_count = 0. Combinational outputs follow: rs_data/rt_data = 0 and fwd_valid is forced to 0 while reset is low, regardless of inputs. A write in flight when reset asserts is lost. Reset release is sampled on clk; the first write is possible on the first rising edge after release.
- X-safety: MemtoReg_in is ignored when regwrite_in = 0; no state changes.
- No stall or enable input. The pipeline register upstream holds values; every cycle with wb_en commits.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, NUM_REGS constants, and REG_ZERO = 0. Reused by the ID, forwarding unit and pipeline registers.
- One natural sub-module: regfile_core. It holds the storage array, async-reset clear, one write port and two raw read ports.
- wb_regfile wraps regfile_core and adds the writeback mux, zero/bypass read logic, forwarding outputs and commit counter.

Test Plan:
1. Reset low 3 cycles, then high; read rs_addr = 1..31 -> all 0; commit_count = 0; fwd_valid = 0 during reset.
2. regwrite_in = 1, MemtoReg_in = 0, address_in = 0x0000_00A5, write_reg_addr_in = 8, rs_addr = 8 -> same cycle rs_data = 0xA5 (bypass). Next cycle with regwrite_in = 0 -> rs_data = 0xA5 (stored); commit_count = 1.
3. regwrite_in = 1, MemtoReg_in = 1, read_data_in = 0xDEAD_BEEF, address_in = 0x1234, write_reg_addr_in = 17, rs_addr = rt_addr = 17 -> both read 0xDEADBEEF; fwd_valid = 1, fwd_addr = 17, fwd_data = 0xDEADBEEF.
4. regwrite_in = 1, write_reg_addr_in = 0, address_in = 0xFFFF_FFFF, rs_addr = 0 -> rs_data = 0; fwd_valid = 0; commit_count unchanged; later read of reg 0 = 0.
5. Write reg 5 = 0x11, then assert reset mid-cycle (between edges) -> rs_data for reg 5 drops to 0 immediately; after release, reg 5 reads 0.
6. Preload commit_count to 2^CNT_W-1 via CNT_W = 4 build and 15 writes; one more write -> commit_count = 0.
